// File: rtl/checker_ctrl_if.sv
// Request/result handshakes and the shared checker-bank bus for checker_ctrl.
// slave = the controller itself; master = host plus checker bank.
interface checker_ctrl_if #(
   parameter int NCHK = 4
);
   logic                 req_valid;
   logic                 req_ready;
   logic [1:0]           req_mode;
   logic [63:0]          req_addr;

   logic [1:0]           cmode;
   logic                 cstart;
   logic [63:0]          caddr;
   logic [NCHK-1:0]      cend_vec;
   logic [8*NCHK-1:0]    cctrl_vec;

   logic                 res_valid;
   logic                 res_ready;
   logic [7:0]           res_ctrl;
   logic [1:0]           res_mode;
   logic                 res_err;
   logic                 busy;

   modport master (
      output req_valid, req_mode, req_addr, cend_vec, cctrl_vec, res_ready,
      input  req_ready, cmode, cstart, caddr, res_valid, res_ctrl, res_mode, res_err, busy
   );

   modport slave (
      input  req_valid, req_mode, req_addr, cend_vec, cctrl_vec, res_ready,
      output req_ready, cmode, cstart, caddr, res_valid, res_ctrl, res_mode, res_err, busy
   );
endinterface

// File: rtl/checker_ctrl.sv
// Serialising dispatcher: one check request -> cstart pulse on the bank bus -> cend -> result.
// Optional macro CHECKER_CTRL_TIMEOUT_EN aborts a WAIT that sees no cend within TIMEOUT cycles.
module checker_ctrl #(
   parameter int NCHK    = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   checker_ctrl_if.slave bus
);
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   localparam logic [2:0] NCHK_W = 3'(NCHK);

   generate
      if (NCHK < 1 || NCHK > 4 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
         $error("checker_ctrl: NCHK must be 1..4 and TIMEOUT 1..65535");
      end
   endgenerate

   state_t      state_q;
   logic        req_ready_q;
   logic        cstart_q;
   logic        res_valid_q;
   logic        res_err_q;
   logic        busy_q;
   logic [1:0]  cmode_q;
   logic [63:0] caddr_q;
   logic [7:0]  res_ctrl_q;

   logic        sel_end;
   logic [7:0]  sel_ctrl;

`ifdef CHECKER_CTRL_TIMEOUT_EN
   logic [15:0] wait_cnt_q;
   logic        wait_expired;

   assign wait_expired = (wait_cnt_q == 16'(TIMEOUT - 1));
`endif

   // Only the selected checker's cend/cctrl are ever looked at.
   always_comb begin
      sel_end  = 1'b0;
      sel_ctrl = 8'h00;
      for (int i = 0; i < NCHK; i++) begin
         if (cmode_q == 2'(i)) begin
            sel_end  = bus.cend_vec[i];
            sel_ctrl = bus.cctrl_vec[8*i +: 8];
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst) begin
      if (!sys_rst) begin
         state_q     <= S_IDLE;
         req_ready_q <= 1'b1;
         cstart_q    <= 1'b0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         busy_q      <= 1'b0;
         cmode_q     <= 2'd0;
         caddr_q     <= 64'd0;
         res_ctrl_q  <= 8'h00;
`ifdef CHECKER_CTRL_TIMEOUT_EN
         wait_cnt_q  <= 16'd0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.req_valid && req_ready_q) begin
                  cmode_q     <= bus.req_mode;
                  caddr_q     <= bus.req_addr;
                  req_ready_q <= 1'b0;
                  busy_q      <= 1'b1;
                  if ({1'b0, bus.req_mode} >= NCHK_W) begin
                     state_q     <= S_DONE;
                     res_valid_q <= 1'b1;
                     res_err_q   <= 1'b1;
                     res_ctrl_q  <= 8'h00;
                  end else begin
                     state_q  <= S_START;
                     cstart_q <= 1'b1;
                  end
               end
            end

            // cend seen during the strobe cycle is deliberately not sampled here.
            S_START: begin
               cstart_q <= 1'b0;
               state_q  <= S_WAIT;
`ifdef CHECKER_CTRL_TIMEOUT_EN
               wait_cnt_q <= 16'd0;
`endif
            end

            S_WAIT: begin
               if (sel_end) begin
                  state_q     <= S_DONE;
                  res_valid_q <= 1'b1;
                  res_err_q   <= 1'b0;
                  res_ctrl_q  <= sel_ctrl;
`ifdef CHECKER_CTRL_TIMEOUT_EN
               end else if (wait_expired) begin
                  state_q     <= S_DONE;
                  res_valid_q <= 1'b1;
                  res_err_q   <= 1'b1;
                  res_ctrl_q  <= 8'h00;
               end else begin
                  wait_cnt_q <= wait_cnt_q + 16'd1;
`endif
               end
            end

            S_DONE: begin
               if (bus.res_ready) begin
                  state_q     <= S_IDLE;
                  res_valid_q <= 1'b0;
                  req_ready_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            end

            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.cmode     = cmode_q;
   assign bus.cstart    = cstart_q;
   assign bus.caddr     = caddr_q;
   assign bus.res_valid = res_valid_q;
   assign bus.res_ctrl  = res_ctrl_q;
   assign bus.res_mode  = cmode_q;
   assign bus.res_err   = res_err_q;
   assign bus.busy      = busy_q;

endmodule
